// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core pipeline: reset defaults, fetch FSM
// encoding and address helpers.
package mips_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] PC_INC            = 32'd4;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between fetch and decode with load, flush and bubble
// controls; anything not commanded holds its contents.
module ifid_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        flush,
   input  logic        bubble,
   input  logic [31:0] load_instr,
   input  logic [31:0] load_pc_plus4,
   output logic        valid,
   output logic        [31:0] instr,
   output logic        [31:0] pc_plus4
);

   // Flush beats load so a redirect always wins over data arriving that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         instr    <= NOP_INSTR;
         pc_plus4 <= 32'd0;
      end else if (flush) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid    <= 1'b1;
         instr    <= load_instr;
         pc_plus4 <= load_pc_plus4;
      end else if (bubble) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs the req/ack fetch handshake and
// drives the IF/ID register, honouring stall and redirect.
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ifid_valid,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc_plus4,
   output logic [15:0] ifid_imm
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  discard_addr;
   logic [31:0]  hold_instr;
   logic [31:0]  hold_pc_plus4;
   logic [31:0]  pc_next_seq;
   logic         ack;

   logic         ifid_load;
   logic         ifid_flush;
   logic         ifid_bubble;
   logic [31:0]  ifid_load_instr;
   logic [31:0]  ifid_load_pc_plus4;

   // DISCARD keeps presenting the abandoned address until memory answers it.
   assign imem_req    = !rst && (state != HOLD);
   assign imem_addr   = (state == DISCARD) ? discard_addr : word_align(pc);
   assign ack         = imem_req && imem_ack;
   assign pc_next_seq = word_align(pc) + PC_INC;
   assign ifid_imm    = ifid_instr[15:0];

   always_comb begin
      ifid_load          = 1'b0;
      ifid_flush         = 1'b0;
      ifid_bubble        = 1'b0;
      ifid_load_instr    = imem_rdata;
      ifid_load_pc_plus4 = pc_next_seq;
      if (redirect) begin
         ifid_flush = 1'b1;
      end else begin
         case (state)
            FETCH: begin
               if (ack && !stall)
                  ifid_load = 1'b1;
               else if (!ack && !stall)
                  ifid_bubble = 1'b1;
            end
            HOLD: begin
               if (!stall) begin
                  ifid_load          = 1'b1;
                  ifid_load_instr    = hold_instr;
                  ifid_load_pc_plus4 = hold_pc_plus4;
               end
            end
            default: begin
               if (!stall)
                  ifid_bubble = 1'b1;
            end
         endcase
      end
   end

   // Redirect overrides stall and ack; a pending request turns into DISCARD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= FETCH;
         pc            <= word_align(RESET_PC);
         discard_addr  <= 32'd0;
         hold_instr    <= NOP_INSTR;
         hold_pc_plus4 <= 32'd0;
      end else begin
         case (state)
            FETCH: begin
               if (redirect) begin
                  pc            <= word_align(redirect_pc);
                  hold_instr    <= NOP_INSTR;
                  hold_pc_plus4 <= 32'd0;
                  if (!ack) begin
                     state        <= DISCARD;
                     discard_addr <= word_align(pc);
                  end
               end else if (ack) begin
                  pc <= pc_next_seq;
                  if (stall) begin
                     hold_instr    <= imem_rdata;
                     hold_pc_plus4 <= pc_next_seq;
                     state         <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc            <= word_align(redirect_pc);
                  hold_instr    <= NOP_INSTR;
                  hold_pc_plus4 <= 32'd0;
                  state         <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            DISCARD: begin
               if (redirect) begin
                  pc            <= word_align(redirect_pc);
                  hold_instr    <= NOP_INSTR;
                  hold_pc_plus4 <= 32'd0;
               end else if (ack) begin
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   ifid_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_ifid_reg (
      .clk          (clk),
      .rst          (rst),
      .load         (ifid_load),
      .flush        (ifid_flush),
      .bubble       (ifid_bubble),
      .load_instr   (ifid_load_instr),
      .load_pc_plus4(ifid_load_pc_plus4),
      .valid        (ifid_valid),
      .instr        (ifid_instr),
      .pc_plus4     (ifid_pc_plus4)
   );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model answers either zero-wait or on
// a bench-driven ack; each scenario task checks its own expected values.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc_plus4;
   logic [15:0] ifid_imm;

   logic        zero_wait;
   logic        man_ack;
   int          errors = 0;
   int          checks = 0;

   if_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .ifid_valid   (ifid_valid),
      .ifid_instr   (ifid_instr),
      .ifid_pc_plus4(ifid_pc_plus4),
      .ifid_imm     (ifid_imm)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'h2008_0005;
      return a ^ 32'hA5A5_0000;
   endfunction

   always_comb begin
      imem_ack   = zero_wait ? imem_req : man_ack;
      imem_rdata = mem_word(imem_addr);
   end

   task automatic do_reset(input logic zw);
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      zero_wait = zw; man_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_addr(input logic [31:0] target);
      checks++;
      for (int i = 0; i < 64; i++) begin
         #1;
         if (imem_req === 1'b1 && imem_addr === target) return;
         @(negedge clk);
      end
      errors++;
      $display("[TB] FAIL wait_addr: timeout, addr=%h want %h", imem_addr, target);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      zero_wait = 1'b0; man_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", ifid_valid); end
      checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h want 00000000", ifid_instr); end
      checks++; if (ifid_pc_plus4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h want 00000000", ifid_pc_plus4); end
      rst = 1'b0;
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_midtxn_req: got %b want 0", imem_req); end
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0; rst = 1'b0;
      #1;
      checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_late_ack: valid=%b addr=%h want 0/00000000", ifid_valid, imem_addr); end
   endtask

   task automatic test_zero_wait();
      do_reset(1'b1);
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL zw_first: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk); #1;
         checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL zw_valid%0d: got %b want 1", k, ifid_valid); end
         checks++; if (ifid_pc_plus4 !== 32'(4 * k)) begin errors++; $display("[TB] FAIL zw_pc4_%0d: got %h want %h", k, ifid_pc_plus4, 32'(4 * k)); end
         checks++; if (ifid_instr !== (32'(4 * (k - 1)) ^ 32'hA5A5_0000)) begin errors++; $display("[TB] FAIL zw_instr%0d: got %h want %h", k, ifid_instr, 32'(4 * (k - 1)) ^ 32'hA5A5_0000); end
         checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("[TB] FAIL zw_addr%0d: got %h want %h", k, imem_addr, 32'(4 * k)); end
      end
   endtask

   task automatic test_wait_states();
      do_reset(1'b0);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL ws_stable%0d: req=%b addr=%h want 1/00000000", c, imem_req, imem_addr); end
         checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_bubble%0d: got %b want 0", c, ifid_valid); end
      end
      @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      checks++; if (ifid_valid !== 1'b1) begin errors++; $display("[TB] FAIL ws_valid: got %b want 1", ifid_valid); end
      checks++; if (ifid_instr !== 32'hA5A5_0000) begin errors++; $display("[TB] FAIL ws_instr: got %h want a5a50000", ifid_instr); end
      checks++; if (ifid_pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL ws_pc4: got %h want 00000004", ifid_pc_plus4); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL ws_next_addr: req=%b addr=%h want 1/00000004", imem_req, imem_addr); end
      @(negedge clk); #1;
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL ws_bubble_after: got %b want 0", ifid_valid); end
   endtask

   task automatic test_stall();
      do_reset(1'b1);
      wait_addr(32'h10);
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req%0d: got %b want 0", i, imem_req); end
         checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA5A5_000C || ifid_pc_plus4 !== 32'h10) begin
            errors++; $display("[TB] FAIL stall_hold%0d: valid=%b instr=%h pc4=%h want 1/a5a5000c/00000010", i, ifid_valid, ifid_instr, ifid_pc_plus4);
         end
      end
      stall = 1'b0;
      @(negedge clk); #1;
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2008_0005) begin errors++; $display("[TB] FAIL stall_release_instr: valid=%b instr=%h want 1/20080005", ifid_valid, ifid_instr); end
      checks++; if (ifid_pc_plus4 !== 32'h14) begin errors++; $display("[TB] FAIL stall_release_pc4: got %h want 00000014", ifid_pc_plus4); end
      checks++; if (ifid_imm !== 16'h0005) begin errors++; $display("[TB] FAIL stall_release_imm: got %h want 0005", ifid_imm); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL stall_next_addr: req=%b addr=%h want 1/00000014", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_pending();
      do_reset(1'b1);
      wait_addr(32'h20);
      zero_wait = 1'b0; man_ack = 1'b0;
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL rd_flush: valid=%b instr=%h want 0/00000000", ifid_valid, ifid_instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL rd_old_addr1: req=%b addr=%h want 1/00000020", imem_req, imem_addr); end
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL rd_old_addr2: req=%b addr=%h want 1/00000020", imem_req, imem_addr); end
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      #1;
      checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL rd_dropped: valid=%b instr=%h want 0/00000000", ifid_valid, ifid_instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rd_new_addr: req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
   endtask

   task automatic test_redirect_stall_ack();
      do_reset(1'b1);
      wait_addr(32'h8);
      stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      stall = 1'b0; redirect = 1'b0;
      #1;
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsa_valid: got %b want 0", ifid_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL rsa_addr: req=%b addr=%h want 1/00000040", imem_req, imem_addr); end
      @(negedge clk); #1;
      checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'hA5A5_0040 || ifid_pc_plus4 !== 32'h44) begin
         errors++; $display("[TB] FAIL rsa_target: valid=%b instr=%h pc4=%h want 1/a5a50040/00000044", ifid_valid, ifid_instr, ifid_pc_plus4);
      end
   endtask

   task automatic test_wrap();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'hFFFF_FFFC || ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_target: addr=%h valid=%b want fffffffc/0", imem_addr, ifid_valid); end
      @(negedge clk); #1;
      checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h0 || ifid_instr !== 32'h5A5A_FFFC) begin
         errors++; $display("[TB] FAIL wrap_ifid: valid=%b pc4=%h instr=%h want 1/00000000/5a5afffc", ifid_valid, ifid_pc_plus4, ifid_instr);
      end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h want 00000000", imem_addr); end
      @(negedge clk); #1;
      checks++; if (ifid_instr !== 32'hA5A5_0000 || ifid_pc_plus4 !== 32'h4) begin errors++; $display("[TB] FAIL wrap_next: instr=%h pc4=%h want a5a50000/00000004", ifid_instr, ifid_pc_plus4); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      zero_wait = 1'b0; man_ack = 1'b0;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_redirect_pending();
      test_redirect_stall_ack();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
